// File: rtl/singleport_ram_arbiter.sv
// Two-requester round-robin arbiter and command sequencer
// for a single-port synchronous RAM with tagged read return.
module singleport_ram_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic                  last_q;
  logic                  last_d;
  logic                  wr_en_q;
  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  rd_v_q;
  logic                  rd_v_d;
  logic                  rd_own_q;
  logic                  rd_own_d;
  logic                  rvalid0_q;
  logic                  rvalid0_d;
  logic                  rvalid1_q;
  logic                  rvalid1_d;
  logic                  accept;
  logic                  sel_we;

  // Grant: lone requester wins; on contention the one not served last wins
  always_comb begin
    gnt0   = rst_n & req0 & (~req1 | last_q);
    gnt1   = rst_n & req1 & (~req0 | ~last_q);
    accept = gnt0 | gnt1;
    sel_we = gnt1 ? we1 : we0;
  end

  // Next state: capture accepted command, shift the read tag pipeline
  always_comb begin
    last_d    = last_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_v_d    = 1'b0;
    rd_own_d  = rd_own_q;
    rvalid0_d = rd_v_q & ~rd_own_q;
    rvalid1_d = rd_v_q & rd_own_q;
    if (accept) begin
      last_d   = gnt1;
      wr_en_d  = sel_we;
      addr_d   = gnt1 ? addr1 : addr0;
      data_d   = gnt1 ? wdata1 : wdata0;
      rd_v_d   = ~sel_we;
      rd_own_d = gnt1;
    end
  end

  // State registers; reset drops any queued write and in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_v_q    <= 1'b0;
      rd_own_q  <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_v_q    <= rd_v_d;
      rd_own_q  <= rd_own_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_addr    = addr_q;
  assign ram_data_in = data_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = ram_data_out;
  assign rdata1      = ram_data_out;

endmodule

// File: tb/tb_singleport_ram_arbiter.sv
// Bench for singleport_ram_arbiter: RAM model, reference
// arbiter model, response scoreboard and directed scenarios.
module tb_singleport_ram_arbiter;
  localparam int DW = 128;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic          we0 = 1'b0;
  logic          we1 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  int checks = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  singleport_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // synchronous single-port RAM, read-first
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  // reference model
  typedef struct packed {
    logic          own;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t rq[$];
  rsp_t r;

  logic          m_last;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_v1;
  logic          m_own1;
  logic          m_v2;
  logic          m_own2;
  logic [DW-1:0] shadow [8];
  logic          eg0;
  logic          eg1;

  assign eg0 = rst_n & req0 & (!req1 | m_last);
  assign eg1 = rst_n & req1 & (!req0 | !m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= 1'b1;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_v1   <= 1'b0;
      m_own1 <= 1'b0;
      m_v2   <= 1'b0;
      m_own2 <= 1'b0;
      rq.delete();
    end else begin
      if (m_wr) shadow[m_addr] <= m_data;
      if (m_v1) rq.push_back({m_own1, shadow[m_addr]});
      m_v2   <= m_v1;
      m_own2 <= m_own1;
      if (eg0 | eg1) begin
        m_last <= eg1;
        m_wr   <= eg1 ? we1 : we0;
        m_addr <= eg1 ? addr1 : addr0;
        m_data <= eg1 ? wdata1 : wdata0;
        m_v1   <= eg1 ? !we1 : !we0;
        m_own1 <= eg1;
      end else begin
        m_wr <= 1'b0;
        m_v1 <= 1'b0;
      end
    end
  end

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ({gnt1, gnt0} !== {eg1, eg0}) begin
        fails++;
        $display("FAIL mon_gnt: got %b%b want %b%b", gnt1, gnt0, eg1, eg0);
      end
      checks++;
      if (ram_wr_en !== m_wr || ram_addr !== m_addr || ram_data_in !== m_data) begin
        fails++;
        $display("FAIL mon_cmd: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                 ram_wr_en, ram_addr, ram_data_in, m_wr, m_addr, m_data);
      end
      checks++;
      if (rvalid0 !== (m_v2 & !m_own2) || rvalid1 !== (m_v2 & m_own2)) begin
        fails++;
        $display("FAIL mon_rvalid: got %b%b want %b%b", rvalid1, rvalid0,
                 m_v2 & m_own2, m_v2 & !m_own2);
      end
      if (m_v2) begin
        checks++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL mon_rsp: got response want empty queue");
        end else begin
          r = rq.pop_front();
          if ((r.own ? rdata1 : rdata0) !== r.data) begin
            fails++;
            $display("FAIL mon_rdata: got %h want %h (req%0d)",
                     r.own ? rdata1 : rdata0, r.data, r.own);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_gnt: got %b%b want 00", gnt1, gnt0);
    end
    checks++;
    if (ram_wr_en !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0
        || ram_addr !== '0 || ram_data_in !== '0) begin
      fails++;
      $display("FAIL reset_out: got we=%b rv=%b%b a=%0d", ram_wr_en,
               rvalid1, rvalid0, ram_addr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL first_contention: got %b%b want 01", gnt1, gnt0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_single_rw();
    req0 = 1'b1;
    we0 = 1'b1;
    addr0 = 3'd5;
    wdata0 = 128'hA5A5;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL single_gnt: got %b%b want 01", gnt1, gnt0);
    end
    tick();
    req0 = 1'b0;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_addr !== 3'd5 || ram_data_in !== 128'hA5A5) begin
      fails++;
      $display("FAIL single_wcmd: got we=%b a=%0d want we=1 a=5", ram_wr_en, ram_addr);
    end
    req0 = 1'b1;
    we0 = 1'b0;
    tick();
    req0 = 1'b0;
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 128'hA5A5 || rvalid1 !== 1'b0) begin
      fails++;
      $display("FAIL single_read: got rv=%b%b d=%h want rv=01 d=a5a5",
               rvalid1, rvalid0, rdata0);
    end
    tick();
    checks++;
    if (rvalid0 !== 1'b0) begin
      fails++;
      $display("FAIL single_pulse: got rvalid0=%b want 0", rvalid0);
    end
  endtask

  task automatic test_sweep();
    int k;
    int first;
    int lastc;
    for (int i = 0; i < 8; i++) begin
      req1 = 1'b1;
      we1 = 1'b1;
      addr1 = AW'(i);
      wdata1 = DW'(i * 3);
      #1;
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        fails++;
        $display("FAIL sweep_wgnt: got %b%b want 10", gnt1, gnt0);
      end
      tick();
    end
    req1 = 1'b0;
    k = 0;
    first = -1;
    lastc = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        req0 = 1'b1;
        we0 = 1'b0;
        addr0 = AW'(i);
      end else begin
        req0 = 1'b0;
      end
      tick();
      if (rvalid0 === 1'b1) begin
        if (first < 0) first = i;
        lastc = i;
        checks++;
        if (rdata0 !== DW'(k * 3)) begin
          fails++;
          $display("FAIL sweep_data: got %0d want %0d", rdata0, k * 3);
        end
        k++;
      end
    end
    checks++;
    if (k != 8 || lastc - first != 7) begin
      fails++;
      $display("FAIL sweep_pulses: got %0d over %0d cycles want 8 over 8",
               k, lastc - first + 1);
    end
  endtask

  task automatic test_raw();
    req1 = 1'b1;
    we1 = 1'b1;
    addr1 = 3'd2;
    wdata1 = DW'(7);
    tick();
    req1 = 1'b0;
    req0 = 1'b1;
    we0 = 1'b0;
    addr0 = 3'd2;
    tick();
    req0 = 1'b0;
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== DW'(7)) begin
      fails++;
      $display("FAIL raw: got rv=%b d=%0d want rv=1 d=7", rvalid0, rdata0);
    end
  endtask

  task automatic test_contention();
    int e;
    int n0;
    int n1;
    req1 = 1'b1;
    we1 = 1'b1;
    addr1 = 3'd6;
    wdata1 = DW'(8'h66);
    tick();
    req0 = 1'b1;
    we0 = 1'b0;
    addr0 = 3'd0;
    we1 = 1'b0;
    addr1 = 3'd1;
    e = 0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (gnt0 !== (e == 0) || gnt1 !== (e == 1)) begin
        fails++;
        $display("FAIL contention_gnt%0d: got %b%b want req%0d", i, gnt1, gnt0, e);
      end
      tick();
      if (e == 0) addr0 = addr0 + 3'd2;
      else addr1 = addr1 + 3'd2;
      e = 1 - e;
      if (rvalid0 === 1'b1) n0++;
      if (rvalid1 === 1'b1) n1++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) begin
      tick();
      if (rvalid0 === 1'b1) n0++;
      if (rvalid1 === 1'b1) n1++;
    end
    checks++;
    if (n0 != 3 || n1 != 3) begin
      fails++;
      $display("FAIL contention_rsp: got %0d/%0d want 3/3", n0, n1);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    req0 = 1'b1;
    we0 = 1'b0;
    addr0 = 3'd3;
    tick();
    req0 = 1'b0;
    #2;
    rst_n = 1'b0;
    cnt = 0;
    repeat (2) begin
      tick();
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) cnt++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL reset_mid: got %0d rvalid pulses want 0", cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_rw();
    test_sweep();
    test_raw();
    test_contention();
    test_reset_mid();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
